// File: rtl/hex_display_scanner_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
package hex_display_scanner_pkg;

  // Bits per displayed hex digit.
  localparam int unsigned DIGIT_W = 4;

  // Short scan slot used by simulation benches instead of the real-board divider.
  localparam int unsigned TICK_DIV_SIM = 4;

  // Widest digit-enable vector supported (NUM_DIGITS is limited to 2..8).
  localparam int unsigned MAX_DIGITS = 8;

  // Maps an active-high one-hot enable onto the board's anode polarity.
  function automatic logic [MAX_DIGITS-1:0] en_polarity(
    input logic [MAX_DIGITS-1:0] en_hot,
    input logic                  active_low
  );
    return active_low ? ~en_hot : en_hot;
  endfunction

endpackage

// File: rtl/hex_display_scanner_tick_gen.sv
// Scan prescaler: free-running 0..TICK_DIV-1 counter with a slot-end tick.
module scan_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_W'(TICK_DIV - 1));

  // Prescaler counter, wraps to zero after the last cycle of each slot.
  always_ff @(posedge clk) begin
    if (reset || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed hex display front end: scans a double-buffered value one digit
// per slot, driving the digit nibble and its anode enable, all registered.
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned TICK_DIV      = 50000,
  parameter bit          EN_ACTIVE_LOW = 1'b1
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] Value,
  input  logic                          Load,
  input  logic                          Blank,
  input  logic                          LeadZeroBlank,
  output logic [DIGIT_W-1:0]            HexVal,
  output logic [NUM_DIGITS-1:0]         DigitEn,
  output logic                          FrameDone
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned VAL_W = DIGIT_W * NUM_DIGITS;

  logic                  tick;
  logic                  boundary;
  logic                  boundary_q;
  logic [IDX_W-1:0]      idx;
  logic [VAL_W-1:0]      active;
  logic [VAL_W-1:0]      pending;
  logic                  pending_flag;
  logic [NUM_DIGITS-1:0] suppress;
  logic [NUM_DIGITS-1:0] en_hot;
  logic [MAX_DIGITS-1:0] en_wide;
  logic [MAX_DIGITS-1:0] en_idle;

  scan_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (Clk),
    .reset(Reset),
    .tick (tick)
  );

  assign boundary = tick && (idx == IDX_W'(NUM_DIGITS - 1));

  // Digit index: advances once per slot, wrapping after the last digit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx <= '0;
    end else if (tick) begin
      idx <= boundary ? '0 : idx + 1'b1;
    end
  end

  // Double buffer: loads park in pending and commit only at a frame boundary;
  // a load landing on the boundary itself goes straight to the active buffer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      active       <= '0;
      pending      <= '0;
      pending_flag <= 1'b0;
    end else if (boundary) begin
      if (Load) begin
        active <= Value;
      end else if (pending_flag) begin
        active <= pending;
      end
      pending_flag <= 1'b0;
    end else if (Load) begin
      pending      <= Value;
      pending_flag <= 1'b1;
    end
  end

  // Digit suppression: a running all-zero check from the top digit down;
  // digit 0 is excluded so a zero value still shows "0".
  always_comb begin
    logic zero_run;
    suppress = '0;
    zero_run = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS - 1; j++) begin
      zero_run = zero_run & (active[DIGIT_W*(NUM_DIGITS-1-j) +: DIGIT_W] == '0);
      suppress[NUM_DIGITS-1-j] = LeadZeroBlank & zero_run;
    end
    if (Blank) begin
      suppress = '1;
    end
    en_hot  = (NUM_DIGITS'(1) << idx) & ~suppress;
    en_wide = en_polarity(MAX_DIGITS'(en_hot), EN_ACTIVE_LOW);
    en_idle = en_polarity('0, EN_ACTIVE_LOW);
  end

  // Output registers; FrameDone is delayed twice so it lines up with the
  // first output cycle of digit 0 rather than with the boundary edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      HexVal     <= '0;
      DigitEn    <= en_idle[NUM_DIGITS-1:0];
      boundary_q <= 1'b0;
      FrameDone  <= 1'b0;
    end else begin
      HexVal     <= active[DIGIT_W*idx +: DIGIT_W];
      DigitEn    <= en_wide[NUM_DIGITS-1:0];
      boundary_q <= boundary;
      FrameDone  <= boundary_q;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner (4 digits, 4-cycle slots, active-low).
module tb_hex_display_scanner;
  import hex_display_scanner_pkg::*;

  localparam int unsigned ND = 4;
  localparam int unsigned TD = TICK_DIV_SIM;
  localparam int unsigned FP = ND * TD;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] Value = '0;
  logic        Load = 1'b0;
  logic        Blank = 1'b0;
  logic        LeadZeroBlank = 1'b0;
  logic [3:0]  HexVal;
  logic [3:0]  DigitEn;
  logic        FrameDone;

  hex_display_scanner #(
    .NUM_DIGITS   (ND),
    .TICK_DIV     (TD),
    .EN_ACTIVE_LOW(1'b1)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Value        (Value),
    .Load         (Load),
    .Blank        (Blank),
    .LeadZeroBlank(LeadZeroBlank),
    .HexVal       (HexVal),
    .DigitEn      (DigitEn),
    .FrameDone    (FrameDone)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] hex;
    logic [3:0] en;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: position within the frame is derived from the number of
  // clock edges since reset; the shown value changes only at frame ends.
  int unsigned k = 0;
  logic [15:0] m_active = '0;
  logic [15:0] m_pend = '0;
  bit          m_pflag = 1'b0;
  bit          m_started = 1'b0;

  initial begin
    exp_t        e;
    int unsigned pos;
    int unsigned dig;
    bit          sup;
    forever begin
      @(posedge Clk);
      if (Reset) begin
        e.hex = 4'h0; e.en = 4'hF; e.fd = 1'b0;
        sb.push_back(e);
        k = 0; m_active = '0; m_pend = '0; m_pflag = 1'b0; m_started = 1'b1;
      end else if (m_started) begin
        pos   = k % FP;
        dig   = pos / TD;
        e.hex = 4'(m_active >> (4 * dig));
        sup   = Blank || (LeadZeroBlank && dig != 0 && (m_active >> (4 * dig)) == 16'h0);
        e.en  = sup ? 4'hF : ~(4'(1) << dig);
        e.fd  = (pos == 0) && (k > 0);
        sb.push_back(e);
        if (pos == FP - 1) begin
          if (Load) m_active = Value;
          else if (m_pflag) m_active = m_pend;
          m_pflag = 1'b0;
        end else if (Load) begin
          m_pend  = Value;
          m_pflag = 1'b1;
        end
        k++;
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  // Monitor: every output cycle is compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("HexVal", HexVal, e.hex);
        chk("DigitEn", DigitEn, e.en);
        chk("FrameDone", {3'b000, FrameDone}, {3'b000, e.fd});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic load_val(input logic [15:0] v);
    Value = v;
    Load  = 1'b1;
    step(1);
    Load  = 1'b0;
  endtask

  // Advance until the next edge will see the given in-frame position.
  task automatic wait_pos(input int unsigned target);
    for (int i = 0; i <= int'(FP) && (k % FP) != target; i++) step(1);
    checks++;
    if ((k % FP) != target) begin
      errors++;
      $display("FAIL wait_pos: got %0d expected %0d", k % FP, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset, then a first value that appears only after the first boundary.
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    load_val(16'h1A3F);
    step(2 * FP + 3);

    // Two loads inside one frame: only the later one is ever shown.
    wait_pos(6);
    load_val(16'h1234);
    step(1);
    load_val(16'h5678);
    step(2 * FP);

    // Load exactly on the boundary cycle overrides the older pending value.
    wait_pos(5);
    load_val(16'h0001);
    wait_pos(FP - 1);
    load_val(16'hBEEF);
    step(2 * FP);

    // Leading-zero suppression, including the all-zero value.
    LeadZeroBlank = 1'b1;
    load_val(16'h00A0);
    step(2 * FP);
    load_val(16'h0000);
    step(2 * FP);
    load_val(16'h0B00);
    step(2 * FP);
    LeadZeroBlank = 1'b0;

    // Blank holds all digits off while scanning continues.
    wait_pos(3);
    Blank = 1'b1;
    step(20);
    Blank = 1'b0;
    step(FP);

    // Reset mid-frame with a load pending discards it.
    load_val(16'h4321);
    step(FP + 2);
    wait_pos(2 * TD + 1);
    load_val(16'h9999);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    step(2 * FP);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      Value = 16'($urandom);
      Load  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) Blank = ~Blank;
      if ($urandom_range(0, 15) == 0) LeadZeroBlank = ~LeadZeroBlank;
      if ($urandom_range(0, 3) == 0) Value = Value & 16'h00FF;
      Reset = ($urandom_range(0, 149) == 0);
      step(1);
    end
    Load  = 1'b0;
    Reset = 1'b0;
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
Multiplexed front end for a multi-digit seven-segment display; sits directly upstream of the Hex27Seg decoder.
Holds a multi-nibble value and scans it one digit at a time: presents the active digit's nibble on HexVal, which feeds Hex27Seg's HexVal input, and drives the matching digit-enable (anode) line.
Value updates are double-buffered and committed only at frame boundaries, so a digit never shows a mix of old and new values.

Parameters:
NUM_DIGITS, 4, number of display digits scanned (2..8)
TICK_DIV, 50000, Clk cycles each digit stays enabled (>=2)
EN_ACTIVE_LOW, 1, 1 = DigitEn active-low (common-anode board), 0 = active-high

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high
Value  in  4*NUM_DIGITS  hex value to display; Value[3:0] is digit 0 (least significant)
Load  in  1  single-cycle strobe: capture Value into the pending buffer
Blank  in  1  level: 1 forces all digits off; counters keep running
LeadZeroBlank  in  1  level: 1 suppresses leading zero digits
HexVal  out  4  nibble of the currently enabled digit, to Hex27Seg
DigitEn  out  NUM_DIGITS  one-hot digit enable, polarity per EN_ACTIVE_LOW
FrameDone  out  1  one-cycle pulse when the last digit's slot ends

Behaviour:
- Reset (sync, on a Clk edge with Reset=1) clears all state:
  - prescaler = 0, digit index = 0, active buffer = 0, pending buffer = 0, pending flag = 0;
  - HexVal = 0, DigitEn = all inactive, FrameDone = 0.
  - Reset asserted mid-frame aborts the scan and discards any pending load.
- Prescaler:
  - counts 0..TICK_DIV-1 and wraps to 0;
  - tick = (prescaler == TICK_DIV-1), combinational and internal.
- Digit index:
  - advances on each tick, wrapping NUM_DIGITS-1 -> 0;
  - frame boundary = tick while index == NUM_DIGITS-1.
- Load handling:
  - Load=1 with no boundary that cycle: pending buffer <= Value, pending flag <= 1;
  - a second Load before the boundary overwrites the pending buffer (last wins);
  - at a boundary with the pending flag set: active buffer <= pending buffer, flag <= 0;
  - Load coinciding with a boundary: active buffer <= Value directly, flag <= 0 (Value takes priority over the older pending value).
- Outputs:
  - all outputs are registered and reflect the index and active buffer with 1-cycle latency;
  - HexVal = active[4*idx +: 4];
  - DigitEn enables only bit idx unless that digit is suppressed.
- Suppression:
  - Blank=1 suppresses all digits;
  - LeadZeroBlank=1 suppresses digit i when nibbles i..NUM_DIGITS-1 of the active buffer are all zero;
  - digit 0 is never suppressed by LeadZeroBlank, so a value of 0 displays "0";
  - when Blank=1, HexVal still tracks the index.
- FrameDone:
  - registered pulse in the cycle after a frame boundary, i.e. aligned with the first output cycle of digit 0;
  - fires whether or not Blank is set.
- Timing at the edges:
  - after Reset deasserts, the first edge drives digit 0 enabled (prescaler 0);
  - digit k is enabled for exactly TICK_DIV cycles per frame;
  - frame period = NUM_DIGITS*TICK_DIV cycles.
- No combinational path from any input to any output.

Decomposition:
- Shared package:
  - DIGIT_W = 4;
  - function for the enable polarity (apply EN_ACTIVE_LOW inversion);
  - simulation default TICK_DIV_SIM = 4.
- One sub-module, scan_tick_gen:
  - prescaler with sync reset;
  - outputs tick;
  - parameter TICK_DIV.
- Top instantiates scan_tick_gen and holds the index, buffers and output registers.
- Hex27Seg is instantiated one level up, not inside this block.

Test Plan:
All scenarios use NUM_DIGITS=4, TICK_DIV=4, EN_ACTIVE_LOW=1.
- Reset then Load Value=16'h1A3F: DigitEn sequence 1110,1101,1011,0111, each held 4 cycles; HexVal F,3,A,1. Display shows 0000 until the first frame boundary, then 1A3F. FrameDone pulses every 16 cycles.
- Load 16'h1234 mid-frame, then Load 16'h5678 two cycles later: no 1234 frame ever appears; the next frame shows 8,7,6,5.
- Load asserted exactly on the boundary cycle (idx=3, prescaler=3) with Value=16'hBEEF while pending=16'h0001: the next frame shows F,E,E,B and the pending flag is cleared.
- LeadZeroBlank=1 with Value=16'h00A0: digits 3 and 2 enables stay 1 (off); digits 1 and 0 are enabled with HexVal A then 0. Value=0: only digit 0 is enabled, showing 0.
- Blank=1 for 20 cycles: DigitEn=1111 throughout while HexVal and FrameDone continue; releasing Blank resumes at the current index with no re-sync.
- Reset asserted while idx=2 with a pending load: the next cycle gives DigitEn=1111, HexVal=0, FrameDone=0; after release, digit 0 is shown and the active buffer reads 0.
